cache_fill_ctrl: RTL and testbench

// - Write-side controller for the 16x16 / 8x32 camera pixel cache SDPB; sits between the OV7670 pixel capture and the cache write port.
// - Packs RGB565 pixels into two ping-pong halves of 8 pixels each. Hands each full half to the downstream PSRAM burst writer with the frame pixel address of its first pixel.
// - Detects and flags overflow when both halves are still pending.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_half_tracker.sv | 71 +++++++
 rtl/cache_fill_ctrl.sv | 126 ++++++++++++
 tb/tb_cache_fill_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the camera pixel cache write side.
// The cache is a 16x16 write / 8x32 read SDPB split into two ping-pong
// halves of eight RGB565 pixels each.
package cache_pkg;

   localparam int CACHE_AW    = 4;
   localparam int HALF_PIXELS = 8;
   localparam int HALF_WORDS  = 4;
   localparam int PIX_W       = 16;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic             half_sel_t;

   // The other ping-pong half.
   function automatic half_sel_t other_half(input half_sel_t h);
      return ~h;
   endfunction

endpackage

// File: rtl/cache_half_tracker.sv
// Tracks which ping-pong halves hold a complete set of eight pixels.
// Also tracks which half is offered to the PSRAM burst writer, and the
// frame pixel address of pixel 0 of each half.
// A half is only offered one cycle after it becomes full. That extra cycle
// lets the final registered cache write land before the consumer reads.
module cache_half_tracker
   import cache_pkg::*;
#(
   parameter int PADDR_W = 19
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               set_en,
   input  logic               set_half,
   input  logic               cap_en,
   input  logic               cap_half,
   input  logic [PADDR_W-1:0] cap_addr,
   input  logic               rd_ack,
   output logic [1:0]         full,
   output logic               rd_req,
   output logic               rd_half,
   output logic [PADDR_W-1:0] rd_base
);

   logic [1:0]         ready;
   half_sel_t          rd_ptr;
   logic [PADDR_W-1:0] base [2];
   logic               ack_fire;
   logic [1:0]         ack_vec;
   logic [1:0]         set_vec;

   assign rd_req   = ready[rd_ptr];
   assign rd_half  = rd_ptr;
   assign rd_base  = base[rd_ptr];
   assign ack_fire = rd_ack & rd_req;

   // Decode the completing half and the acknowledged half into one-hot vectors.
   always_comb begin
      ack_vec = 2'b00;
      set_vec = 2'b00;
      if (ack_fire) begin
         ack_vec[rd_ptr] = 1'b1;
      end
      if (set_en) begin
         set_vec[set_half] = 1'b1;
      end
   end

   // Full/ready flags, the drain pointer and the per-half base addresses.
   // A completing half is always a non-full half. An acknowledged half is
   // always a full half, so both events can take effect in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         full    <= 2'b00;
         ready   <= 2'b00;
         rd_ptr  <= 1'b0;
         base[0] <= '0;
         base[1] <= '0;
      end else begin
         full  <= (full & ~ack_vec) | set_vec;
         ready <= full & ~ack_vec;
         if (ack_fire) begin
            rd_ptr <= other_half(rd_ptr);
         end
         if (cap_en) begin
            base[cap_half] <= cap_addr;
         end
      end
   end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Write-side controller for the camera pixel cache.
// It packs captured RGB565 pixels into two ping-pong halves. Each full half
// is handed to the PSRAM burst writer with the frame address of its first
// pixel. A pixel that arrives while its target half is still pending is
// dropped and flagged.
// Optional feature macro: CACHE_FILL_DROP_CNT_EN. When it is defined, this
// enables a saturating dropped-pixel counter on drop_cnt. When it is not
// defined, drop_cnt is tied to zero.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int FRAME_PIXELS = 307200,
   parameter int PADDR_W      = 19
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_start,
   input  logic                pix_valid,
   input  logic [PIX_W-1:0]    pix_data,
   output logic                cache_cea,
   output logic [CACHE_AW-1:0] cache_ada,
   output logic [PIX_W-1:0]    cache_din,
   output logic                rd_req,
   output logic                rd_half,
   output logic [PADDR_W-1:0]  rd_base,
   input  logic                rd_ack,
   output logic                overflow,
   output logic [15:0]         drop_cnt
);

   localparam logic [2:0]         LAST_IDX  = 3'(HALF_PIXELS - 1);
   localparam logic [PADDR_W-1:0] LAST_ADDR = PADDR_W'(FRAME_PIXELS - 1);

   half_sel_t          wr_half;
   logic [2:0]         wr_idx;
   logic [PADDR_W-1:0] pix_addr;
   logic [PADDR_W-1:0] pix_addr_next;
   logic [1:0]         full;
   logic               accept;
   logic               drop;
   logic               half_done;
   logic               base_capture;

   // Classify the incoming pixel. frame_start takes priority and discards it.
   always_comb begin
      accept        = pix_valid & ~frame_start & ~full[wr_half];
      drop          = pix_valid & ~frame_start &  full[wr_half];
      half_done     = accept & (wr_idx == LAST_IDX);
      base_capture  = accept & (wr_idx == 3'd0);
      pix_addr_next = (pix_addr == LAST_ADDR) ? '0 : pix_addr + 1'b1;
   end

   // Register the cache write port and maintain the write counters.
   // pix_addr advances for dropped pixels too, so later pixels keep their
   // true frame position.
   always_ff @(posedge clk) begin
      if (reset) begin
         cache_cea <= 1'b0;
         cache_ada <= '0;
         cache_din <= '0;
         wr_half   <= 1'b0;
         wr_idx    <= '0;
         pix_addr  <= '0;
         overflow  <= 1'b0;
      end else begin
         cache_cea <= accept;
         if (accept) begin
            cache_ada <= {wr_half, wr_idx};
            cache_din <= pix_data;
         end
         if (frame_start) begin
            wr_idx   <= '0;
            pix_addr <= '0;
            overflow <= 1'b0;
         end else begin
            if (pix_valid) begin
               pix_addr <= pix_addr_next;
            end
            if (accept) begin
               wr_idx <= wr_idx + 3'd1;
               if (half_done) begin
                  wr_half <= other_half(wr_half);
               end
            end
            if (drop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

`ifdef CACHE_FILL_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   // Count dropped pixels, saturating, cleared at each frame start.
   always_ff @(posedge clk) begin
      if (reset || frame_start) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

   cache_half_tracker #(
      .PADDR_W (PADDR_W)
   ) u_tracker (
      .clk      (clk),
      .reset    (reset),
      .set_en   (half_done),
      .set_half (wr_half),
      .cap_en   (base_capture),
      .cap_half (wr_half),
      .cap_addr (pix_addr),
      .rd_ack   (rd_ack),
      .full     (full),
      .rd_req   (rd_req),
      .rd_half  (rd_half),
      .rd_base  (rd_base)
   );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl.
// The frame is shortened to 64 pixels so that pixel-address wrap is
// reachable in a few dozen cycles.
module tb_cache_fill_ctrl;

   localparam int FRAME_PIXELS = 64;
   localparam int PADDR_W      = 19;

   logic               clk = 1'b0;
   logic               reset;
   logic               frame_start;
   logic               pix_valid;
   logic [15:0]        pix_data;
   logic               cache_cea;
   logic [3:0]         cache_ada;
   logic [15:0]        cache_din;
   logic               rd_req;
   logic               rd_half;
   logic [PADDR_W-1:0] rd_base;
   logic               rd_ack;
   logic               overflow;
   logic [15:0]        drop_cnt;

   int check_count = 0;
   int error_count = 0;

   cache_fill_ctrl #(
      .FRAME_PIXELS (FRAME_PIXELS),
      .PADDR_W      (PADDR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .cache_cea   (cache_cea),
      .cache_ada   (cache_ada),
      .cache_din   (cache_din),
      .rd_req      (rd_req),
      .rd_half     (rd_half),
      .rd_base     (rd_base),
      .rd_ack      (rd_ack),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream n back-to-back pixels starting at the given data value.
   task automatic applyStimulus(input int n, input logic [15:0] first);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_data  = first + 16'(i);
         tick();
      end
      pix_valid = 1'b0;
   endtask

   // One-cycle rd_ack pulse.
   task automatic pulseAck();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
   endtask

   // Two-cycle synchronous reset with idle inputs.
   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Bound the whole run in case something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      pix_data    = '0;
      rd_ack      = 1'b0;
      doReset();

      checkOutput("reset_cea",      32'(cache_cea), 32'd0);
      checkOutput("reset_ada",      32'(cache_ada), 32'd0);
      checkOutput("reset_din",      32'(cache_din), 32'd0);
      checkOutput("reset_rd_req",   32'(rd_req),    32'd0);
      checkOutput("reset_rd_half",  32'(rd_half),   32'd0);
      checkOutput("reset_rd_base",  32'(rd_base),   32'd0);
      checkOutput("reset_overflow", 32'(overflow),  32'd0);
      checkOutput("reset_drop_cnt", 32'(drop_cnt),  32'd0);

      // An ack with nothing offered must be ignored.
      pulseAck();

      // Eight pixels 1..8 land at ada 0..7, one write per pixel.
      for (int i = 0; i < 8; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(i + 1);
         tick();
         checkOutput("fill0_cea", 32'(cache_cea), 32'd1);
         checkOutput("fill0_ada", 32'(cache_ada), 32'(i));
         checkOutput("fill0_din", 32'(cache_din), 32'(i + 1));
      end
      pix_valid = 1'b0;
      checkOutput("fill0_req_early", 32'(rd_req), 32'd0);
      tick();
      checkOutput("fill0_cea_idle", 32'(cache_cea), 32'd0);
      checkOutput("fill0_rd_req",   32'(rd_req),    32'd1);
      checkOutput("fill0_rd_half",  32'(rd_half),   32'd0);
      checkOutput("fill0_rd_base",  32'(rd_base),   32'd0);

      // Pixels 9..16 fill half 1. Pixels 17..24 are dropped.
      for (int i = 0; i < 8; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(i + 9);
         tick();
         checkOutput("fill1_ada", 32'(cache_ada), 32'(i + 8));
      end
      pix_valid = 1'b1;
      pix_data  = 16'd17;
      tick();
      checkOutput("drop_cea",      32'(cache_cea), 32'd0);
      checkOutput("drop_overflow", 32'(overflow),  32'd1);
      applyStimulus(7, 16'd18);
      tick();
      checkOutput("ovf_overflow", 32'(overflow), 32'd1);
`ifdef CACHE_FILL_DROP_CNT_EN
      checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd8);
`else
      checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      checkOutput("ovf_rd_req",  32'(rd_req),  32'd1);
      checkOutput("ovf_rd_half", 32'(rd_half), 32'd0);
      checkOutput("ovf_rd_base", 32'(rd_base), 32'd0);

      // frame_start clears overflow, but the full halves stay pending.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checkOutput("fs_overflow", 32'(overflow), 32'd0);
      checkOutput("fs_drop_cnt", 32'(drop_cnt), 32'd0);
      checkOutput("fs_rd_req",   32'(rd_req),   32'd1);
      checkOutput("fs_rd_base",  32'(rd_base),  32'd0);

      // An ack of half 0 in the same cycle as the 8th pixel of half 1.
      doReset();
      applyStimulus(8, 16'h0100);
      applyStimulus(7, 16'h0200);
      pix_valid = 1'b1;
      pix_data  = 16'h00AA;
      rd_ack    = 1'b1;
      tick();
      pix_valid = 1'b0;
      rd_ack    = 1'b0;
      checkOutput("sim_cea", 32'(cache_cea), 32'd1);
      checkOutput("sim_ada", 32'(cache_ada), 32'd15);
      checkOutput("sim_din", 32'(cache_din), 32'h00AA);
      tick();
      checkOutput("sim_rd_req",  32'(rd_req),  32'd1);
      checkOutput("sim_rd_half", 32'(rd_half), 32'd1);
      checkOutput("sim_rd_base", 32'(rd_base), 32'd8);

      // Five pixels, then frame_start with a competing pixel, then a fresh half.
      doReset();
      applyStimulus(5, 16'h0300);
      pix_valid   = 1'b1;
      frame_start = 1'b1;
      pix_data    = 16'hDEAD;
      tick();
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      checkOutput("fsp_cea", 32'(cache_cea), 32'd0);
      for (int i = 0; i < 8; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(16'h0400 + i);
         tick();
         checkOutput("fsp_ada", 32'(cache_ada), 32'(i));
      end
      pix_valid = 1'b0;
      tick();
      checkOutput("fsp_rd_req",   32'(rd_req),   32'd1);
      checkOutput("fsp_rd_half",  32'(rd_half),  32'd0);
      checkOutput("fsp_rd_base",  32'(rd_base),  32'd0);
      checkOutput("fsp_overflow", 32'(overflow), 32'd0);

      // Drain seven halves, then straddle the 64-pixel frame wrap.
      doReset();
      for (int k = 0; k < 7; k++) begin
         applyStimulus(8, 16'(k * 8));
         tick();
         checkOutput("drain_rd_base", 32'(rd_base), 32'(k * 8));
         pulseAck();
      end
      applyStimulus(8, 16'h0500);
      tick();
      checkOutput("wrap_rd_half_a", 32'(rd_half), 32'd1);
      checkOutput("wrap_rd_base_a", 32'(rd_base), 32'(FRAME_PIXELS - 8));
      applyStimulus(8, 16'h0600);
      tick();
      pulseAck();
      checkOutput("wrap_rd_req_b",  32'(rd_req),  32'd1);
      checkOutput("wrap_rd_half_b", 32'(rd_half), 32'd0);
      checkOutput("wrap_rd_base_b", 32'(rd_base), 32'd0);

      // Reset while a half is offered and a pixel is presented.
      reset     = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 16'h0BAD;
      tick();
      reset     = 1'b0;
      pix_valid = 1'b0;
      checkOutput("rst_rd_req",   32'(rd_req),    32'd0);
      checkOutput("rst_cea",      32'(cache_cea), 32'd0);
      checkOutput("rst_overflow", 32'(overflow),  32'd0);
      checkOutput("rst_rd_base",  32'(rd_base),   32'd0);
      applyStimulus(1, 16'h0055);
      checkOutput("rst_next_cea", 32'(cache_cea), 32'd1);
      checkOutput("rst_next_ada", 32'(cache_ada), 32'd0);
      checkOutput("rst_next_din", 32'(cache_din), 32'h0055);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
